// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side bundle for uart_rx.
//   Frame configuration (two_stop_bits_i, parity_bit_i, parity_even_i,
//   clock_divider_i) and the raw serial line flow into the receiver;
//   data_o, valid_o, parity_error_o, framing_error_o and busy_o flow out.
//   break_o exists only when UART_RX_BREAK_DETECT_EN is defined.
// master: the side that configures the link and consumes bytes.
// slave : the receiver itself.
interface uart_rx_if;
    logic        two_stop_bits_i;
    logic        parity_bit_i;
    logic        parity_even_i;
    logic [15:0] clock_divider_i;
    logic        serial_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        parity_error_o;
    logic        framing_error_o;
    logic        busy_o;
`ifdef UART_RX_BREAK_DETECT_EN
    logic        break_o;
`endif

    modport master (
        output two_stop_bits_i, parity_bit_i, parity_even_i, clock_divider_i, serial_i,
        input  data_o, valid_o, parity_error_o, framing_error_o, busy_o
`ifdef UART_RX_BREAK_DETECT_EN
        , input break_o
`endif
    );

    modport slave (
        input  two_stop_bits_i, parity_bit_i, parity_even_i, clock_divider_i, serial_i,
        output data_o, valid_o, parity_error_o, framing_error_o, busy_o
`ifdef UART_RX_BREAK_DETECT_EN
        , output break_o
`endif
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (1 start, 8 data LSB first,
// optional parity, 1 or 2 stop bits), runtime-configured bit period.
// Ports:
//   clock_i - system clock, rising edge
//   reset_i - asynchronous active-high reset
//   bus     - uart_rx_if.slave: configuration + serial_i in; byte, valid
//             strobe, error flags, busy (and break_o) out
// Optional feature: define UART_RX_BREAK_DETECT_EN to add break detection.
module uart_rx (
    input logic      clock_i,
    input logic      reset_i,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

    state_t      state;
    logic        sync1, rx;
    logic [15:0] cnt;
    logic [15:0] div_l;
    logic        two_l, par_l, even_l;
    logic [2:0]  bitn;
    logic [7:0]  sh;
    logic        pe_r, fe_r, par_s;
    logic        mid, start_ok, last_stop;
`ifdef UART_RX_BREAK_DETECT_EN
    logic        stop_hi, brk_wait, brk_now;
`endif

    // Both flops reset high so reset release never looks like a start edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= bus.serial_i;
            rx    <= sync1;
        end
    end

    // The counter reads 0 on the cycle IDLE sees the start edge, so sampling
    // at cnt == div/2 lands every sample at div/2 + k*N.
    assign mid       = (cnt == {1'b0, div_l[15:1]});
    assign last_stop = mid && ((state == STOP1 && !two_l) || state == STOP2);
`ifdef UART_RX_BREAK_DETECT_EN
    assign start_ok  = !rx && !brk_wait;
    assign brk_now   = (sh == 8'h00) && !par_s && !stop_hi && !rx;
`else
    assign start_ok  = !rx;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state               <= ARM;
            cnt                 <= 16'd0;
            div_l               <= 16'd0;
            two_l               <= 1'b0;
            par_l               <= 1'b0;
            even_l              <= 1'b0;
            bitn                <= 3'd0;
            sh                  <= 8'h00;
            pe_r                <= 1'b0;
            fe_r                <= 1'b0;
            par_s               <= 1'b0;
            bus.data_o          <= 8'h00;
            bus.valid_o         <= 1'b0;
            bus.parity_error_o  <= 1'b0;
            bus.framing_error_o <= 1'b0;
            bus.busy_o          <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            bus.break_o         <= 1'b0;
            stop_hi             <= 1'b0;
            brk_wait            <= 1'b0;
`endif
        end else begin
            bus.valid_o <= 1'b0;
            case (state)
                // Line must be idle for a full bit period before we trust an edge.
                ARM: begin
                    if (!rx) begin
                        cnt <= 16'd0;
                    end else if (cnt == bus.clock_divider_i) begin
                        cnt        <= 16'd0;
                        state      <= IDLE;
                        bus.busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (rx) brk_wait <= 1'b0;
`endif
                    if (start_ok) begin
                        div_l      <= bus.clock_divider_i;
                        two_l      <= bus.two_stop_bits_i;
                        par_l      <= bus.parity_bit_i;
                        even_l     <= bus.parity_even_i;
                        cnt        <= 16'd1;
                        bitn       <= 3'd0;
                        pe_r       <= 1'b0;
                        fe_r       <= 1'b0;
                        par_s      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        stop_hi    <= 1'b0;
`endif
                        state      <= START;
                        bus.busy_o <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                end
                default: begin
                    cnt <= (cnt == div_l) ? 16'd0 : cnt + 16'd1;
                    if (mid) begin
                        if (state == START) begin
                            // High at mid-start means a glitch: drop it silently.
                            if (rx) begin
                                state      <= IDLE;
                                bus.busy_o <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else if (state == DATA) begin
                            sh   <= {rx, sh[7:1]};
                            bitn <= bitn + 3'd1;
                            if (bitn == 3'd7) state <= par_l ? PARITY : STOP1;
                        end else if (state == PARITY) begin
                            par_s <= rx;
                            pe_r  <= (^sh) ^ rx ^ ~even_l;
                            state <= STOP1;
                        end else begin
                            fe_r <= fe_r | ~rx;
`ifdef UART_RX_BREAK_DETECT_EN
                            stop_hi <= stop_hi | rx;
`endif
                            if (state == STOP1 && two_l) state <= STOP2;
                        end
                    end
                    // Results are registered on the final stop sample so they
                    // are visible in the one DONE cycle alongside valid_o.
                    if (last_stop) begin
                        state               <= DONE;
                        bus.valid_o         <= 1'b1;
                        bus.data_o          <= sh;
                        bus.parity_error_o  <= pe_r;
                        bus.framing_error_o <= fe_r | ~rx;
`ifdef UART_RX_BREAK_DETECT_EN
                        bus.break_o         <= brk_now;
                        brk_wait            <= brk_now;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if bus();
    uart_rx u_dut (.clock_i(clk), .reset_i(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    int         vcnt = 0;
    logic [7:0] cap_d;
    logic       cap_pe, cap_fe, cap_brk;

    always @(negedge clk) begin
        if (bus.valid_o) begin
            vcnt   = vcnt + 1;
            cap_d  = bus.data_o;
            cap_pe = bus.parity_error_o;
            cap_fe = bus.framing_error_o;
`ifdef UART_RX_BREAK_DETECT_EN
            cap_brk = bus.break_o;
`else
            cap_brk = 1'b0;
`endif
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       par_en, even, two, par_b, stop1, stop2;
        logic [7:0] ed;
        logic       epe, efe, ebrk;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send_bit(input logic b);
        bus.serial_i = b;
        repeat (N) @(negedge clk);
    endtask

    task automatic send_frame(input vec_t f);
        bus.parity_bit_i    = f.par_en;
        bus.parity_even_i   = f.even;
        bus.two_stop_bits_i = f.two;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(f.d[i]);
        if (f.par_en) send_bit(f.par_b);
        send_bit(f.stop1);
        if (f.two) send_bit(f.stop2);
        bus.serial_i = 1'b1;
        repeat (3 * N) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t f, input string nm);
        int v0;
        v0 = vcnt;
        send_frame(f);
        chk({nm, " valid_pulses"}, vcnt - v0, 1);
        chk({nm, " data"}, cap_d, f.ed);
        chk({nm, " parity_err"}, cap_pe, f.epe);
        chk({nm, " framing_err"}, cap_fe, f.efe);
`ifdef UART_RX_BREAK_DETECT_EN
        chk({nm, " break"}, cap_brk, f.ebrk);
`endif
        chk({nm, " busy_after"}, bus.busy_o, 0);
        chk({nm, " data_held"}, bus.data_o, f.ed);
    endtask

    initial begin
        int   v0;
        vec_t f;
        //        d      pe    ev    two   pb    s1    s2    ed     epe   efe   ebrk
        v[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
        v[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        v[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
        v[4] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        v[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        v[6] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        v[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        v[8] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        v[9] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};

        bus.serial_i        = 1'b1;
        bus.clock_divider_i = 16'd15;
        bus.two_stop_bits_i = 1'b0;
        bus.parity_bit_i    = 1'b0;
        bus.parity_even_i   = 1'b0;

        // Reset values, then arming time with the line idle.
        repeat (3) @(negedge clk);
        chk("rst data", bus.data_o, 8'h00);
        chk("rst valid", bus.valid_o, 0);
        chk("rst pe", bus.parity_error_o, 0);
        chk("rst fe", bus.framing_error_o, 0);
        chk("rst busy", bus.busy_o, 1);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("arm busy_at_15", bus.busy_o, 1);
        @(negedge clk);
        chk("arm busy_at_16", bus.busy_o, 0);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(v[i], $sformatf("vec%0d", i));

        // Short low pulse must be rejected as a glitch.
        v0 = vcnt;
        bus.serial_i = 1'b0;
        repeat (4) @(negedge clk);
        bus.serial_i = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch busy", bus.busy_o, 0);
        repeat (40) @(negedge clk);
        chk("glitch no_valid", vcnt - v0, 0);

        // Reset after four data bits of a frame.
        v0 = vcnt;
        bus.parity_bit_i = 1'b0;
        bus.two_stop_bits_i = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst data", bus.data_o, 8'h00);
        chk("midrst valid", bus.valid_o, 0);
        chk("midrst pe", bus.parity_error_o, 0);
        chk("midrst fe", bus.framing_error_o, 0);
        chk("midrst busy", bus.busy_o, 1);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("midrst break", bus.break_o, 0);
`endif
        bus.serial_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst no_valid", vcnt - v0, 0);
        chk("midrst rearmed", bus.busy_o, 0);
        f = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        run_vec(f, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with `UartTx`: recovers 8-bit frames from an asynchronous line and presents each byte with a one-cycle valid strobe and per-frame error flags. Frame format (1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits) and bit rate are runtime-configured with the same inputs the transmitter uses, so one register bank drives both ends of a link. Sits between the pad-side serial input and the host byte interface.

## Interface
- No parameters; all configuration is through runtime inputs.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clock_i`  in  1  system clock; all state is updated on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `two_stop_bits_i`  in  1  1: expect two stop bits.
- `parity_bit_i`  in  1  1: a parity bit follows the data bits.
- `parity_even_i`  in  1  1: even parity; 0: odd parity. Ignored when `parity_bit_i`=0.
- `clock_divider_i`  in  16  bit period minus one, in clocks (N = `clock_divider_i`+1).
- `serial_i`  in  1  asynchronous serial line; idles high.
- `data_o`  out  8  last received byte.
- `valid_o`  out  1  one-cycle pulse when a frame completes.
- `parity_error_o`  out  1  parity mismatch in the last frame.
- `framing_error_o`  out  1  a stop bit was sampled low in the last frame.
- `busy_o`  out  1  high while arming or receiving a frame.
- `break_o`  out  1  break flag; present only with `UART_RX_BREAK_DETECT_EN`.

## Operation
- Input path: 2-flop synchronizer on `serial_i`, both flops reset to 1. The FSM sees only the synchronized value `rx`.
- `two_stop_bits_i`, `parity_bit_i`, `parity_even_i` and `clock_divider_i` are latched on start-edge detection and stay fixed for the rest of the frame.
- FSM states:
  - ARM (reset state): `rx` must stay high for N consecutive clocks. The counter restarts on any low. Then go to IDLE. This prevents locking onto a mid-frame edge after reset.
  - IDLE: on `rx`=0, clear the bit counter and go to START.
  - START: sample `rx` at mid-bit. If `rx`=1, treat it as a glitch and go to IDLE with no `valid_o` and no flag change. If `rx`=0, go to DATA.
  - DATA: take 8 samples, one per N clocks, shifting LSB first. Then go to PARITY if enabled, else STOP1.
  - PARITY: sample one bit. Even parity: the XOR of the 8 data bits and the parity bit must be 0. Odd parity: it must be 1.
  - STOP1: sample one bit. Go to STOP2 if two stop bits are selected, else go to DONE.
  - STOP2: sample one bit, then go to DONE.
  - DONE: lasts one cycle. Update `data_o` and both error flags, pulse `valid_o`, go to IDLE. IDLE may then detect the next start edge on the following cycle.
- `framing_error_o` = 1 if any stop-bit sample is 0.
- `parity_error_o` = 0 when parity is disabled.
- `data_o`, `parity_error_o` and `framing_error_o` are updated only in DONE and held until the next DONE.
- `busy_o` = 1 in every state except IDLE.
- Reset asserted mid-frame: the frame is discarded, all outputs return to reset values, and the FSM enters ARM.

## Timing
- Reset values: `data_o`=8'h00, `valid_o`=0, `parity_error_o`=0, `framing_error_o`=0, `busy_o`=1, `break_o`=0.
- Synchronizer latency: 2 clocks from the `serial_i` edge to `rx`.
- Sample schedule: let cycle 0 be the cycle IDLE sees `rx`=0. Sample k (k=0 is the start bit) occurs at cycle `(clock_divider_i>>1)` + k·N.
- `valid_o` is high on the cycle after the final stop sample. That cycle is the only cycle in which `valid_o` is high.
- Counter: 16-bit, counts 0..`clock_divider_i`, then wraps to 0.
- Supported range: `clock_divider_i` ≥ 3. Smaller values are not required to receive correctly.
- No backpressure: each frame overwrites `data_o` unconditionally.

## Configuration
- `UART_RX_BREAK_DETECT_EN` defined:
  - Adds output `break_o`.
  - `break_o` is set in DONE when all data bits are 0, the parity sample (if enabled) is 0, and the stop sample is 0.
  - `break_o` is cleared on the next DONE that does not meet that condition.
  - ARM is not entered after a break frame; IDLE waits for `rx` to return high before accepting a start edge.
- `UART_RX_BREAK_DETECT_EN` undefined: no `break_o` port; a break is reported only as `framing_error_o`=1 with `data_o`=8'h00.

## Test plan
- Arming: release reset with the line high and divider=15. Required: `busy_o`=1 for 16 clocks, then 0.
- Basic frame: divider=15, 8N1, send 8'hA5. Required: one `valid_o` pulse, `data_o`=8'hA5, both error flags 0, `busy_o`=0 afterwards.
- Parity error: even parity, two stop bits, send 8'h07 with parity bit 0. Required: `data_o`=8'h07, `parity_error_o`=1. Then send 8'h03 with parity 0. Required: `parity_error_o` clears.
- Framing error: 8N1, send 8'h3C with the stop bit driven low. Required: `data_o`=8'h3C, `framing_error_o`=1. With the macro defined, send a 10-bit-low frame. Required: `break_o`=1.
- Glitch rejection: drive `serial_i` low for 4 clocks with divider=15. Required: no `valid_o`, `busy_o` back to 0 within 10 clocks.
- Reset mid-frame: assert reset after 4 data bits. Required: all outputs at reset values, and no `valid_o` is produced for the aborted frame. Then send 8'h5A after re-arming. Required: `data_o`=8'h5A with no errors.
